ps2_kbd_rx: RTL and testbench

//  - PS/2 keyboard receiver for the LC-3 keyboard path; receive end of the serial link our keyboard model drives.
//  - Deserialises 11-bit frames (start=0, 8 data LSB-first, odd parity, stop=1) sampled on ps2_clk falling edges.
//  - Presents the scan code with a KBSR-style ready flag, held until the CPU's KBDR read acknowledges it.

---
 rtl/ps2_kbd_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deserialises 11-bit frames and
// presents scan codes with a KBSR-style ready flag. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_kbd_rx #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       rdy,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    // state  | meaning
    // IDLE   | waiting for a start bit (fall with data=0)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the parity bit
    // STOP   | checking stop bit; accept or drop the frame
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;

    logic clk_s, dat_s, fall, timeout, accept, drop, parity_ok;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign dat_s   = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_s;
    assign timeout = (state_q != IDLE) && !fall && (timer_q == '0);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (state_q == PARITY && fall) begin
            parity_d = dat_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    // odd parity: data bits plus parity bit must contain an odd number of ones
    assign parity_ok = ^{shreg_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d = clk_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall && !dat_s) state_d = DATA;
            end
            DATA: begin
                if (timeout) state_d = IDLE;
                else if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
                if (timeout) state_d = IDLE;
                else if (fall) state_d = STOP;
            end
            STOP: begin
                if (timeout || fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        busy   = (state_q != IDLE);
        if (timeout) begin
            drop = 1'b1;
        end else if (state_q == STOP && fall) begin
            if (dat_s && parity_ok) accept = 1'b1;
            else drop = 1'b1;
        end
    end

    // Timer is reloaded on every strobe; hitting zero between strobes aborts the frame.
    always_comb begin
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (state_q == IDLE || fall) begin
            timer_d = TIMER_LOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end
        if (state_q == IDLE && fall && !dat_s) begin
            bit_cnt_d = 3'd0;
        end else if (state_q == DATA && fall) begin
            shreg_d[bit_cnt_q] = dat_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
        end
    end

    // A frame arriving while rdy is held keeps the oldest code unless the CPU reads in that cycle.
    always_comb begin
        data_d      = data_q;
        rdy_d       = rdy_q;
        overrun_d   = overrun_q;
        frame_err_d = drop;
        if (accept) begin
            if (!rdy_q || rd_ack) begin
                data_d = shreg_q;
                rdy_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rd_ack) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_prev_q  <= 1'b1;
            timer_q     <= TIMER_LOAD;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            rdy_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks the KBSR/KBDR-style outputs.
module tb_ps2_kbd_rx;

    localparam int HALF = 10;
    localparam int SS   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       rdy, overrun, frame_err, busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int err_cnt  = 0;

    ps2_kbd_rx #(.TIMEOUT_CYCLES(10000), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_ack(rd_ack),
        .data(data), .rdy(rdy), .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits, input bit ack_at, output int lat);
        logic rdy0;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            rdy0    = rdy;
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                tick(1);
                if (ack_at && i == nbits - 1) begin
                    if (k == 2) rd_ack = 1'b1;
                    else if (k == 3) rd_ack = 1'b0;
                end
                if (i == nbits - 1 && lat == 0 && rdy === 1'b1 && rdy0 === 1'b0) lat = k;
            end
            ps2_clk = 1'b1;
        end
        tick(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        chk_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_single_frame();
        int lat, e0;
        e0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, lat);
        chk_cnt++; if (data !== 8'h1C) $display("FAIL single_data: got %h expected 1c", data); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL single_rdy: got %b expected 1", rdy); else pass_cnt++;
        chk_cnt++; if (lat < 1 || lat > SS + 2) $display("FAIL single_latency: got %0d expected 1..%0d", lat, SS + 2); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL single_frame_err: got %0d expected 0", err_cnt - e0); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int lat, e0;
        e0 = err_cnt;
        send_bits(mk_frame(8'h32, 1'b0, 1'b1), 11, 1'b0, lat);
        chk_cnt++; if (data !== 8'h1C) $display("FAIL overrun_data: got %h expected 1c", data); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b expected 1", overrun); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL overrun_rdy: got %b expected 1", rdy); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL overrun_frame_err: got %0d expected 0", err_cnt - e0); else pass_cnt++;
        pulse_ack();
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL ack_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL ack_overrun: got %b expected 0", overrun); else pass_cnt++;
        pulse_ack();
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL idle_ack_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (data !== 8'h1C) $display("FAIL idle_ack_data: got %h expected 1c", data); else pass_cnt++;
    endtask

    task automatic test_ack_coincident();
        int lat;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0, lat);
        send_bits(mk_frame(8'h32, 1'b0, 1'b1), 11, 1'b1, lat);
        chk_cnt++; if (data !== 8'h32) $display("FAIL coinc_data: got %h expected 32", data); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL coinc_rdy: got %b expected 1", rdy); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL coinc_overrun: got %b expected 0", overrun); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_bad_stop();
        int lat, e0;
        e0 = err_cnt;
        send_bits(mk_frame(8'h5A, 1'b1, 1'b0), 11, 1'b0, lat);
        chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL badstop_err_cycles: got %0d expected 1", err_cnt - e0); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL badstop_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (data !== 8'h32) $display("FAIL badstop_data: got %h expected 32", data); else pass_cnt++;
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 1'b0, lat);
        chk_cnt++; if (data !== 8'hF0) $display("FAIL recover_data: got %h expected f0", data); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL recover_err_cycles: got %0d expected 1", err_cnt - e0); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_idle_noise();
        int lat, e0;
        e0 = err_cnt;
        send_bits(11'h7FF, 1, 1'b0, lat);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL noise_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL noise_frame_err: got %0d expected 0", err_cnt - e0); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int lat, e0;
        e0 = err_cnt;
        send_bits(mk_frame(8'h12, 1'b1, 1'b1), 4, 1'b0, lat);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL partial_busy: got %b expected 1", busy); else pass_cnt++;
        tick(9860);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL pre_timeout_busy: got %b expected 1", busy); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL pre_timeout_err: got %0d expected 0", err_cnt - e0); else pass_cnt++;
        tick(220);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL timeout_err_cycles: got %0d expected 1", err_cnt - e0); else pass_cnt++;
        send_bits(mk_frame(8'h12, 1'b1, 1'b1), 11, 1'b0, lat);
        chk_cnt++; if (data !== 8'h12) $display("FAIL post_timeout_data: got %h expected 12", data); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL post_timeout_rdy: got %b expected 1", rdy); else pass_cnt++;
        pulse_ack();
    endtask

    task automatic test_parity();
        int lat, e0;
        e0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, 1'b0, lat);
`ifdef PS2_PARITY_CHECK_EN
        chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL parity_err_cycles: got %0d expected 1", err_cnt - e0); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL parity_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (data !== 8'h12) $display("FAIL parity_data: got %h expected 12", data); else pass_cnt++;
`else
        chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL parity_err_cycles: got %0d expected 0", err_cnt - e0); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL parity_rdy: got %b expected 1", rdy); else pass_cnt++;
        chk_cnt++; if (data !== 8'h1C) $display("FAIL parity_data: got %h expected 1c", data); else pass_cnt++;
`endif
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 1'b0, lat);
        send_bits(mk_frame(8'h55, 1'b1, 1'b1), 5, 1'b0, lat);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b0) $display("FAIL midrst_rdy: got %b expected 0", rdy); else pass_cnt++;
        chk_cnt++; if (data !== 8'h00) $display("FAIL midrst_data: got %h expected 00", data); else pass_cnt++;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send_bits(mk_frame(8'h33, 1'b1, 1'b1), 11, 1'b0, lat);
        chk_cnt++; if (data !== 8'h33) $display("FAIL midrst_next_data: got %h expected 33", data); else pass_cnt++;
        chk_cnt++; if (rdy !== 1'b1) $display("FAIL midrst_next_rdy: got %b expected 1", rdy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_ack_coincident();
        test_bad_stop();
        test_idle_noise();
        test_timeout();
        test_parity();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
